ov7670_capture: RTL and testbench
=================================

// Module: ov7670_capture
// PURPOSE
// - Camera-side capture stage directly downstream of the OV7670 parallel bus (PCLK/VSYNC/HREF/D[7:0]).
// - Pairs RGB565 bytes into pixels and reduces each pixel to RGB444.
// - Emits linear frame-buffer writes (we/addr/wdata) to the dual-port frame buffer read by the VGA side.
// - Runs entirely in the camera PCLK domain; frame start and end are taken from VSYNC.
// PARAMETERS
// - H_ACTIVE  640  pixels (byte pairs) accepted per HREF line
// - V_ACTIVE  480  lines accepted per frame
// - ADDR_W    19   frame-buffer address width; must hold H_ACTIVE*V_ACTIVE-1
// PORTS
// - pclk        in   1       camera pixel clock; all logic on rising edge
// - rst_n       in   1       async active-low reset
// - cap_en      in   1       capture enable; sampled only at frame start
// - vsync       in   1       camera VSYNC, active high
// - href        in   1       camera HREF, active high during valid bytes
// - d           in   8       camera data byte
// - we          out  1       frame-buffer write strobe, 1 cycle per pixel
// - addr        out  ADDR_W  write address, row-major from 0
// - wdata       out  12      {R[3:0],G[3:0],B[3:0]}
// - frame_done  out  1       1-cycle pulse, end of a captured frame
// - busy        out  1       high while in ACTIVE state
// - err_line    out  1       sticky: odd byte count, or line longer than H_ACTIVE
// - err_clr     in   1       synchronous clear of err_line (err_clr wins over a new error)
// BEHAVIOUR
// - Input stage: vsync, href and d are registered once (vsync_q, href_q, d_q); all decisions use the registered copies.
// - Reset values: we=0, addr=0, wdata=0, frame_done=0, busy=0, err_line=0, state=IDLE, byte phase=0.
// - FSM IDLE: wait for vsync_q=1 -> SYNC.
// - FSM SYNC: on vsync_q falling edge: if cap_en=1 go to ACTIVE (addr, line, col cleared), else go to IDLE.
// - FSM ACTIVE: on vsync_q rising edge go to SYNC and pulse frame_done the same cycle.
// - Mid-frame reset returns to IDLE. The remainder of that frame is discarded; capture resumes after the next full VSYNC pulse.
// - Byte pairing: within href_q=1, phase 0 byte is held as hi; phase 1 byte completes the pixel, lo=d_q.
//   Phase resets to 0 whenever href_q=0.
// - Pixel conversion: R=hi[7:4], G={hi[2:0],lo[7]}, B=lo[4:1].
// - Latency: the write occurs 1 pclk after the cycle in which lo is present in d_q.
//   Total latency is 2 pclk from the lo byte on pins to we=1.
// - Address: col counts 0..H_ACTIVE-1 and line counts 0..V_ACTIVE-1.
//   addr = line*H_ACTIVE+col, maintained incrementally with no multiplier.
// - Line end: on href_q falling edge, line increments if col>0. A phase=1 leftover (odd byte count) sets err_line and is dropped.
// - Overlong line: pixels with col==H_ACTIVE are not written; err_line set once per line; col saturates.
// - Excess lines: lines with line>=V_ACTIVE produce no writes and raise no error.
// - VSYNC rising mid-line aborts the line. Written pixels stay valid; frame_done still pulses.
// - we never asserts outside ACTIVE. At most one write per 2 pclk.
// CONFIGURATION
// - CAPTURE_DOWNSCALE_EN defined: 2:1 decimation in both axes.
//   Only even col and even line pixels are written; addr = (line/2)*(H_ACTIVE/2)+(col/2).
//   640x480 gives 76800 writes, last addr 76799.
//   Overlong and excess-line rules apply on the source counts.
// - CAPTURE_DOWNSCALE_EN undefined: full resolution, as described above.
// TESTING
// - Full frame: vsync high for 3*1568 pclk, 480 lines of 1280 bytes with a 288-byte gap.
//   Expect 307200 we pulses, last addr 307199, one frame_done, err_line=0.
// - Pixel packing: bytes 0xF8,0x1F -> wdata=0xF0F. Bytes 0x07,0xE0 -> wdata=0x0F0.
//   we asserts 2 pclk after the second byte is on the pins.
// - Odd line: 1281 bytes on line 0 -> err_line=1, line-0 writes = 640.
//   err_clr for 1 cycle -> err_line=0.
// - Overlong line: 1300 bytes -> 640 writes, addr of first write on line 1 = 640, err_line=1.
// - cap_en=0 at vsync fall -> zero writes and no frame_done that frame.
//   cap_en=1 on the next frame -> capture restarts at addr 0.
// - rst_n pulse mid-line 100 -> outputs return to reset values, nothing written until the next VSYNC completes.
//   CAPTURE_DOWNSCALE_EN build: full frame -> 76800 writes, last addr 76799.

Source files
------------

// File: rtl/ov7670_capture.sv
// OV7670 capture: pairs RGB565 bytes, reduces them to RGB444 and emits linear frame-buffer writes.
// Optional build macro CAPTURE_DOWNSCALE_EN selects 2:1 decimation in both axes.
module ov7670_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              cap_en,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic              err_clr,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [11:0]       wdata,
    output logic              frame_done,
    output logic              busy,
    output logic              err_line
);

    localparam int COL_W  = $clog2(H_ACTIVE + 1);
    localparam int LINE_W = $clog2(V_ACTIVE + 1);
    localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(H_ACTIVE);
    localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(V_ACTIVE);
`ifdef CAPTURE_DOWNSCALE_EN
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE / 2);
`else
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);
`endif

    typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

    state_t              state_q, state_d;
    logic                vsync_q, vsync_d, vsync_prev_q, vsync_prev_d;
    logic                href_q, href_d, href_prev_q, href_prev_d;
    logic [7:0]          d_q, d_d;
    logic [6:0]          hi_q, hi_d;
    logic                phase_q, phase_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [11:0]         wdata_q, wdata_d;
    logic                frame_done_q, frame_done_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic                vsync_rise, vsync_fall, href_fall, pix_done, line_ok, keep_pix, err_set;
    logic [ADDR_W-1:0]   pix_addr;
    logic                unused_bits;

    // hi_q keeps only the bits that survive the RGB565 -> RGB444 reduction
    assign unused_bits = ^{d_q[6:5], d_q[0]};

    assign vsync_rise = vsync_q & ~vsync_prev_q;
    assign vsync_fall = ~vsync_q & vsync_prev_q;
    assign href_fall  = href_prev_q & ~href_q;
    assign pix_done   = href_q & phase_q;
    assign line_ok    = line_q < LINE_MAX;

`ifdef CAPTURE_DOWNSCALE_EN
    assign keep_pix = ~col_q[0] & ~line_q[0];
    assign pix_addr = base_q + ADDR_W'(col_q >> 1);
`else
    assign keep_pix = 1'b1;
    assign pix_addr = base_q + ADDR_W'(col_q);
`endif

    always_comb begin
        state_d      = state_q;
        vsync_d      = vsync;
        vsync_prev_d = vsync_q;
        href_d       = href;
        href_prev_d  = href_q;
        d_d          = d;
        hi_d         = hi_q;
        phase_d      = href_q ? ~phase_q : 1'b0;
        col_d        = col_q;
        line_d       = line_q;
        base_d       = base_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        frame_done_d = 1'b0;
        err_set      = 1'b0;

        if (href_q && !phase_q) begin
            hi_d = {d_q[7:4], d_q[2:0]};
        end

        case (state_q)
            IDLE: begin
                if (vsync_q) state_d = SYNC;
            end
            SYNC: begin
                if (vsync_fall) begin
                    if (cap_en) begin
                        state_d = ACTIVE;
                        col_d   = '0;
                        line_d  = '0;
                        base_d  = '0;
                        addr_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ACTIVE: begin
                if (vsync_rise) begin
                    state_d      = SYNC;
                    frame_done_d = 1'b1;
                end else begin
                    if (pix_done) begin
                        if (col_q < COL_MAX) begin
                            col_d = col_q + COL_W'(1);
                            if (line_ok && keep_pix) begin
                                we_d    = 1'b1;
                                addr_d  = pix_addr;
                                wdata_d = {hi_q[6:3], hi_q[2:0], d_q[7], d_q[4:1]};
                            end
                        end else if (line_ok) begin
                            err_set = 1'b1;
                        end
                    end
                    // Lines past V_ACTIVE are counted out but never advance the address base
                    if (href_fall) begin
                        col_d = '0;
                        if (phase_q && line_ok) err_set = 1'b1;
                        if (col_q != '0 && line_ok) begin
                            line_d = line_q + LINE_W'(1);
`ifdef CAPTURE_DOWNSCALE_EN
                            if (line_q[0]) base_d = base_q + LINE_STEP;
`else
                            base_d = base_q + LINE_STEP;
`endif
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (err_clr)      err_d = 1'b0;
        else if (err_set) err_d = 1'b1;
        else              err_d = err_q;

        busy_d = (state_d == ACTIVE);
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
            href_q       <= 1'b0;
            href_prev_q  <= 1'b0;
            d_q          <= '0;
            hi_q         <= '0;
            phase_q      <= 1'b0;
            col_q        <= '0;
            line_q       <= '0;
            base_q       <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            vsync_prev_q <= vsync_prev_d;
            href_q       <= href_d;
            href_prev_q  <= href_prev_d;
            d_q          <= d_d;
            hi_q         <= hi_d;
            phase_q      <= phase_d;
            col_q        <= col_d;
            line_q       <= line_d;
            base_q       <= base_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign we         = we_q;
    assign addr       = addr_q;
    assign wdata      = wdata_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign err_line   = err_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture: a frame-level reference model pushes expected writes
// (address, pixel, arrival cycle) while a monitor pops and compares every we pulse.
module tb_ov7670_capture;

    localparam int H   = 16;
    localparam int V   = 8;
    localparam int AW  = 8;
    localparam int GAP = 6;
    localparam int VS  = 6;

    logic          pclk = 1'b0;
    logic          rst_n, cap_en, vsync, href, err_clr;
    logic [7:0]    d;
    logic          we, frame_done, busy, err_line;
    logic [AW-1:0] addr;
    logic [11:0]   wdata;

    ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .pclk(pclk), .rst_n(rst_n), .cap_en(cap_en), .vsync(vsync), .href(href), .d(d),
        .err_clr(err_clr), .we(we), .addr(addr), .wdata(wdata), .frame_done(frame_done),
        .busy(busy), .err_line(err_line)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int addr;
        int wdata;
        int cyc;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] pre_bytes[$];
    int         frame_lines[$];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         exp_done = 0;
    int         seen_done = 0;
    int         total_writes = 0;
    int         last_addr = -1;
    int         probe0 = -1;
    int         probe1 = -1;
    int         mline = 0;
    bit         probe_en = 0;
    bit         captured = 0;
    bit         exp_err = 0;
    bit         abort_last = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    // Monitor: expected writes that went past their arrival cycle are reported as missing
    always @(negedge pclk) begin
        if (frame_done) seen_done++;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            mon_e = exp_q.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL missing_write addr=%0d expected at cycle %0d, still absent at cycle %0d", mon_e.addr, mon_e.cyc, cyc);
        end
        if (we) begin
            total_writes++;
            last_addr = int'(addr);
            if (probe_en && addr == 0) probe0 = int'(wdata);
            if (probe_en && addr == 1) probe1 = int'(wdata);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write addr=%0d wdata=%03h at cycle %0d", addr, wdata, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (int'(addr) != mon_e.addr || int'(wdata) != mon_e.wdata) begin
                    errors++;
                    $display("[TB] FAIL write_data actual addr=%0d wdata=%03h required addr=%0d wdata=%03h", addr, wdata, mon_e.addr, mon_e.wdata);
                end
                checks++;
                if (cyc != mon_e.cyc) begin
                    errors++;
                    $display("[TB] FAIL write_latency actual cycle=%0d required cycle=%0d", cyc, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #(200000 * 10);
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Reference pixel: R = hi[7:4], G = {hi[2:0], lo[7]}, B = lo[4:1]
    function automatic int rgb444(input int hi, input int lo);
        return ((hi >> 4) << 8) | ((((hi & 7) << 1) | ((lo >> 7) & 1)) << 4) | ((lo >> 1) & 15);
    endfunction

    task automatic send_line(input int n, input bit leave_high);
        int hi_b, b, p;
        hi_b = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            b    = (pre_bytes.size() > 0) ? int'(pre_bytes.pop_front()) : int'($urandom_range(0, 255));
            href = 1'b1;
            d    = 8'(b);
            if (i % 2 == 0) begin
                hi_b = b;
            end else if (captured && mline < V) begin
                p = i / 2;
`ifdef CAPTURE_DOWNSCALE_EN
                if (p < H && p % 2 == 0 && mline % 2 == 0)
                    exp_q.push_back('{(mline / 2) * (H / 2) + p / 2, rgb444(hi_b, b), cyc + 2});
`else
                if (p < H)
                    exp_q.push_back('{mline * H + p, rgb444(hi_b, b), cyc + 2});
`endif
            end
        end
        if (!leave_high) begin
            @(negedge pclk);
            href = 1'b0;
            d    = 8'($urandom_range(0, 255));
            if (captured && mline < V && (n % 2 == 1 || n / 2 > H)) exp_err = 1'b1;
            if (captured && n >= 2) mline++;
            repeat (GAP) @(negedge pclk);
        end
    endtask

    task automatic applyStimulus(input bit cap);
        @(negedge pclk);
        href  = 1'b0;
        vsync = 1'b1;
        cap_en = cap;
        if (captured) exp_done++;
        captured = 1'b0;
        repeat (VS - 1) @(negedge pclk);
        @(negedge pclk);
        vsync    = 1'b0;
        captured = cap;
        mline    = 0;
        repeat (4) @(negedge pclk);
        foreach (frame_lines[k]) send_line(frame_lines[k], abort_last && (k == frame_lines.size() - 1));
        if (!abort_last) repeat (4) @(negedge pclk);
    endtask

    task automatic clear_err();
        @(negedge pclk);
        err_clr = 1'b1;
        @(negedge pclk);
        err_clr = 1'b0;
        exp_err = 1'b0;
        @(negedge pclk);
        checkOutput("err_after_clear", int'(err_line), 0);
    endtask

    task automatic frame_checks(input string tag);
        checkOutput({tag, "_err_line"}, int'(err_line), int'(exp_err));
        checkOutput({tag, "_busy"}, int'(busy), int'(captured));
        checkOutput({tag, "_frame_done"}, seen_done, exp_done);
        checkOutput({tag, "_pending"}, exp_q.size(), 0);
    endtask

    int base_w;

    initial begin
        rst_n = 1'b0; cap_en = 1'b0; vsync = 1'b0; href = 1'b0; d = 8'h00; err_clr = 1'b0;
        repeat (3) @(negedge pclk);
        checkOutput("reset_we", int'(we), 0);
        checkOutput("reset_addr", int'(addr), 0);
        checkOutput("reset_wdata", int'(wdata), 0);
        checkOutput("reset_frame_done", int'(frame_done), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_err_line", int'(err_line), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge pclk);

        // Full frame with the packing patterns at the start of line 0
`ifdef CAPTURE_DOWNSCALE_EN
        pre_bytes = '{8'hF8, 8'h1F, 8'h00, 8'h00, 8'h07, 8'hE0};
`else
        pre_bytes = '{8'hF8, 8'h1F, 8'h07, 8'hE0};
`endif
        frame_lines = {};
        for (int i = 0; i < V; i++) frame_lines.push_back(2 * H);
        base_w = total_writes;
        probe_en = 1'b1;
        applyStimulus(1'b1);
        probe_en = 1'b0;
        frame_checks("full");
`ifdef CAPTURE_DOWNSCALE_EN
        checkOutput("full_write_count", total_writes - base_w, (H / 2) * (V / 2));
        checkOutput("full_last_addr", last_addr, (H / 2) * (V / 2) - 1);
`else
        checkOutput("full_write_count", total_writes - base_w, H * V);
        checkOutput("full_last_addr", last_addr, H * V - 1);
`endif
        checkOutput("pack_f81f", probe0, 12'hF0F);
        checkOutput("pack_07e0", probe1, 12'h0F0);

        frame_lines = '{2 * H + 1, 2 * H, 2 * H};
        applyStimulus(1'b1);
        frame_checks("odd_line");
        clear_err();

        frame_lines = '{2 * H + 20, 2 * H, 2 * H};
        applyStimulus(1'b1);
        frame_checks("overlong");
        clear_err();

        frame_lines = {};
        for (int i = 0; i < V; i++) frame_lines.push_back(2 * H);
        frame_lines.push_back(2 * H + 1);
        frame_lines.push_back(2 * H + 20);
        applyStimulus(1'b1);
        frame_checks("excess_lines");

        frame_lines = '{2 * H, 2 * H};
        base_w = total_writes;
        applyStimulus(1'b0);
        frame_checks("cap_off");
        checkOutput("cap_off_writes", total_writes - base_w, 0);

        frame_lines = '{2 * H, 10};
        abort_last = 1'b1;
        applyStimulus(1'b1);
        abort_last = 1'b0;
        checkOutput("abort_busy", int'(busy), 1);

        frame_lines = '{2 * H, 2 * H};
        applyStimulus(1'b1);
        send_line(10, 1'b1);
        @(negedge pclk);
        d = 8'($urandom_range(0, 255));
        captured = 1'b0;
        @(negedge pclk);
        d = 8'($urandom_range(0, 255));
        #1 rst_n = 1'b0;
        exp_err = 1'b0;
        @(negedge pclk);
        d = 8'($urandom_range(0, 255));
        checkOutput("midreset_we", int'(we), 0);
        checkOutput("midreset_addr", int'(addr), 0);
        checkOutput("midreset_wdata", int'(wdata), 0);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_err_line", int'(err_line), 0);
        checkOutput("midreset_frame_done", int'(frame_done), 0);
        @(negedge pclk);
        #1 rst_n = 1'b1;
        base_w = total_writes;
        send_line(20, 1'b0);
        send_line(2 * H, 1'b0);
        checkOutput("midreset_writes", total_writes - base_w, 0);

        frame_lines = '{2 * H, 2 * H, 2 * H};
        applyStimulus(1'b1);
        frame_checks("after_reset");

        for (int f = 0; f < 6; f++) begin
            frame_lines = {};
            for (int i = 0; i < int'($urandom_range(1, V + 2)); i++)
                frame_lines.push_back(int'($urandom_range(0, 2 * H + 6)));
            applyStimulus(1'($urandom_range(0, 3) != 0));
            frame_checks("random");
            if (err_line) clear_err();
        end

        frame_lines = {};
        applyStimulus(1'b0);
        repeat (10) @(negedge pclk);
        frame_checks("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
